// File: rtl/regfile_access_ctrl.sv
// Initiator-side controller for a 32x32 register file with one shared R_W port.
// Each request runs a read phase, an optional write phase, then a response phase.
module regfile_access_ctrl #(
  parameter int DATA_W       = 32,
  parameter int ADDR_W       = 5,
  parameter int ZERO_PROTECT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_rs,
  input  logic [ADDR_W-1:0] req_rt,
  input  logic [ADDR_W-1:0] req_rd,
  input  logic              req_we,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rs_data,
  output logic [DATA_W-1:0] rsp_rt_data,
  output logic              rf_r_w,
  output logic [ADDR_W-1:0] rf_reg1,
  output logic [ADDR_W-1:0] rf_reg2,
  output logic [ADDR_W-1:0] rf_address,
  output logic [DATA_W-1:0] rf_data_in,
  input  logic [DATA_W-1:0] rf_data_out_1,
  input  logic [DATA_W-1:0] rf_data_out_2
);

  typedef enum logic [1:0] {IDLE, RD, WR, RSP} state_t;

  state_t            state_reg;
  logic [ADDR_W-1:0] rd_reg;
  logic              we_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic              write_en;

  // Writes to r0 are dropped on the port but the transaction still completes.
  assign write_en = we_reg && !((ZERO_PROTECT != 0) && (rd_reg == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      req_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_rs_data <= '0;
      rsp_rt_data <= '0;
      rf_r_w      <= 1'b0;
      rf_reg1     <= '0;
      rf_reg2     <= '0;
      rf_address  <= '0;
      rf_data_in  <= '0;
      rd_reg      <= '0;
      we_reg      <= 1'b0;
      wdata_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (req_valid && req_ready) begin
            // rf_reg1/rf_reg2 double as the latched rs/rt for the whole transaction.
            rf_reg1   <= req_rs;
            rf_reg2   <= req_rt;
            rd_reg    <= req_rd;
            we_reg    <= req_we;
            wdata_reg <= req_wdata;
            req_ready <= 1'b0;
            state_reg <= RD;
          end else begin
            req_ready <= 1'b1;
          end
        end
        RD: begin
          // Operands are captured before any write, giving read-before-write semantics.
          rsp_rs_data <= rf_data_out_1;
          rsp_rt_data <= rf_data_out_2;
          if (write_en) begin
            rf_r_w     <= 1'b1;
            rf_address <= rd_reg;
            rf_data_in <= wdata_reg;
            state_reg  <= WR;
          end else begin
            rsp_valid <= 1'b1;
            state_reg <= RSP;
          end
        end
        WR: begin
          rf_r_w     <= 1'b0;
          rf_address <= '0;
          rf_data_in <= '0;
          rsp_valid  <= 1'b1;
          state_reg  <= RSP;
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Self-checking bench: behavioural register file plus a transaction-level model
// of the expected operands, write pulses and handshake timing.
module tb_regfile_access_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [4:0]  req_rs, req_rt, req_rd;
  logic        req_we;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rs_data, rsp_rt_data;
  logic        rf_r_w;
  logic [4:0]  rf_reg1, rf_reg2, rf_address;
  logic [31:0] rf_data_in, rf_data_out_1, rf_data_out_2;

  regfile_access_ctrl #(.DATA_W(32), .ADDR_W(5), .ZERO_PROTECT(1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_rs(req_rs), .req_rt(req_rt), .req_rd(req_rd),
    .req_we(req_we), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rs_data(rsp_rs_data), .rsp_rt_data(rsp_rt_data),
    .rf_r_w(rf_r_w), .rf_reg1(rf_reg1), .rf_reg2(rf_reg2),
    .rf_address(rf_address), .rf_data_in(rf_data_in),
    .rf_data_out_1(rf_data_out_1), .rf_data_out_2(rf_data_out_2)
  );

  always #5 clk = ~clk;

  // Register file: combinational read, write on the rising edge when R_W=1.
  logic [31:0] init_vals [32];
  logic [31:0] env_mem   [32];
  logic        init_en;
  always @(posedge clk) begin
    if (init_en) env_mem <= init_vals;
    else if (rf_r_w) env_mem[rf_address] <= rf_data_in;
  end
  assign rf_data_out_1 = env_mem[rf_reg1];
  assign rf_data_out_2 = env_mem[rf_reg2];

  typedef struct {
    logic [4:0]  rs, rt, rd;
    logic        we;
    logic [31:0] wd;
  } req_t;

  req_t        reqs [64];
  logic [31:0] model [32];
  int          total = 0;
  int          bad = 0;
  int          ncyc = 0;
  int          last_acc = 0;
  int          exp_gap = -1;

  task automatic chk(input logic [63:0] obs, input logic [63:0] exp, input string tag);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    ncyc++;
  endtask

  task automatic present(input int i);
    req_valid = 1'b1;
    req_rs    = reqs[i].rs;
    req_rt    = reqs[i].rt;
    req_rd    = reqs[i].rd;
    req_we    = reqs[i].we;
    req_wdata = reqs[i].wd;
  endtask

  // Entered at a negedge with request i already presented.
  task automatic run_txn(input int i, input int stall, input bit has_next);
    req_t        r;
    logic [31:0] exp_rs, exp_rt;
    int          exp_wr, exp_lat, n, lat, wr_cnt, acc;
    r       = reqs[i];
    exp_rs  = model[r.rs];
    exp_rt  = model[r.rt];
    exp_wr  = (r.we && r.rd != 5'd0) ? 1 : 0;
    exp_lat = (exp_wr != 0) ? 3 : 2;
    if (exp_wr != 0) model[r.rd] = r.wd;

    n = 0;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    chk(req_ready, 1, "accept_wait");
    acc = ncyc;
    if (exp_gap >= 0) chk(acc - last_acc, exp_gap, "accept_period");
    last_acc = acc;

    lat = 0;
    wr_cnt = 0;
    do begin
      tick();
      lat++;
      if (lat == 1) begin
        if (has_next) present(i + 1);
        else req_valid = 1'b0;
        chk({rf_reg1, rf_reg2}, {r.rs, r.rt}, "rd_indices");
      end
      chk(req_ready, 0, "busy_ready");
      if (rf_r_w) begin
        wr_cnt++;
        chk({rf_address, rf_data_in}, {r.rd, r.wd}, "wr_port");
      end else begin
        chk({rf_address, rf_data_in}, 0, "idle_port");
      end
    end while (!rsp_valid && lat < 8);
    chk(lat, exp_lat, "rsp_latency");
    chk(wr_cnt, exp_wr, "wr_pulses");
    chk({rsp_rs_data, rsp_rt_data}, {exp_rs, exp_rt}, "rsp_data");

    for (int s = 0; s < stall; s++) begin
      tick();
      chk({rsp_valid, req_ready, rf_r_w}, 3'b100, "stall_ctrl");
      chk({rsp_rs_data, rsp_rt_data}, {exp_rs, exp_rt}, "stall_data");
    end
    rsp_ready = 1'b1;
    $display("txn %0d rs=%0d rt=%0d rd=%0d we=%0d wd=%08h -> rs_data=%08h rt_data=%08h lat=%0d",
             i, r.rs, r.rt, r.rd, r.we, r.wd, rsp_rs_data, rsp_rt_data, lat);
    tick();
    rsp_ready = 1'b0;
    chk({rsp_valid, req_ready}, 2'b01, "post_handshake");
    exp_gap = has_next ? exp_lat + stall + 1 : -1;
  endtask

  task automatic single(input int i, input int stall);
    tick();
    present(i);
    run_txn(i, stall, 1'b0);
  endtask

  initial begin
    int  n;
    bit  prev_next, nxt;

    for (int k = 0; k < 32; k++) init_vals[k] = $urandom;
    init_vals[0] = 32'd0;
    init_vals[1] = 32'd15;
    init_vals[3] = 32'd21;
    init_vals[5] = 32'd27;
    for (int k = 0; k < 32; k++) model[k] = init_vals[k];

    reqs[0]  = '{rs: 5'd1, rt: 5'd3, rd: 5'd2, we: 1'b0, wd: 32'h1111_1111};
    reqs[1]  = '{rs: 5'd5, rt: 5'd5, rd: 5'd5, we: 1'b1, wd: 32'hDEAD_BEEF};
    reqs[2]  = '{rs: 5'd5, rt: 5'd1, rd: 5'd0, we: 1'b0, wd: 32'h0};
    reqs[3]  = '{rs: 5'd0, rt: 5'd3, rd: 5'd0, we: 1'b1, wd: 32'd7};
    reqs[4]  = '{rs: 5'd0, rt: 5'd0, rd: 5'd4, we: 1'b0, wd: 32'h0};
    reqs[5]  = '{rs: 5'd3, rt: 5'd1, rd: 5'd6, we: 1'b1, wd: 32'hCAFE_0006};
    reqs[6]  = '{rs: 5'd6, rt: 5'd2, rd: 5'd7, we: 1'b0, wd: 32'h0};
    reqs[7]  = '{rs: 5'd1, rt: 5'd6, rd: 5'd8, we: 1'b0, wd: 32'h0};
    reqs[8]  = '{rs: 5'd8, rt: 5'd3, rd: 5'd8, we: 1'b1, wd: 32'h0808_0808};
    reqs[9]  = '{rs: 5'd8, rt: 5'd9, rd: 5'd9, we: 1'b1, wd: 32'h0909_0909};
    reqs[10] = '{rs: 5'd9, rt: 5'd8, rd: 5'd1, we: 1'b0, wd: 32'h0};
    for (int k = 11; k <= 40; k++) begin
      reqs[k].rs = 5'($urandom_range(0, 31));
      reqs[k].rt = 5'($urandom_range(0, 31));
      reqs[k].rd = ($urandom_range(0, 3) == 0) ? reqs[k].rs : 5'($urandom_range(0, 31));
      reqs[k].we = 1'($urandom_range(0, 1));
      reqs[k].wd = $urandom;
    end
    reqs[41] = '{rs: 5'd2, rt: 5'd4, rd: 5'd10, we: 1'b1, wd: 32'hBAD0_0010};
    reqs[42] = '{rs: 5'd10, rt: 5'd0, rd: 5'd0, we: 1'b0, wd: 32'h0};

    rst = 1'b1; init_en = 1'b1;
    req_valid = 1'b0; req_rs = '0; req_rt = '0; req_rd = '0; req_we = 1'b0; req_wdata = '0;
    rsp_ready = 1'b0;
    tick(); tick();
    chk({req_ready, rsp_valid, rf_r_w}, 0, "reset_ctrl");
    chk({rf_address, rf_data_in, rf_reg1, rf_reg2}, 0, "reset_port");
    chk({rsp_rs_data, rsp_rt_data}, 0, "reset_rsp");
    rst = 1'b0; init_en = 1'b0;
    tick();
    chk(req_ready, 1, "idle_ready");

    // Directed: plain read, read-before-write, readback, r0 protection.
    single(0, 0);
    single(1, 0);
    single(2, 0);
    single(3, 0);
    chk(env_mem[0], 0, "r0_protected");
    // Backpressure with the next request waiting.
    tick();
    present(4);
    run_txn(4, 10, 1'b1);
    run_txn(5, 0, 1'b0);
    single(6, 0);
    // Back-to-back, mixed with and without writes.
    tick();
    present(7);
    run_txn(7, 0, 1'b1);
    run_txn(8, 0, 1'b1);
    run_txn(9, 0, 1'b1);
    run_txn(10, 0, 1'b0);

    // Random traffic.
    prev_next = 1'b0;
    for (int k = 11; k <= 40; k++) begin
      if (!prev_next) begin
        tick();
        present(k);
      end
      nxt = (k < 40) && ($urandom_range(0, 1) == 1);
      run_txn(k, int'($urandom_range(0, 3)), nxt);
      prev_next = nxt;
    end

    // Reset while the write is on the port: write must be abandoned.
    tick();
    present(41);
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    chk(req_ready, 1, "rstwr_accept");
    tick();
    req_valid = 1'b0;
    tick();
    chk({rf_r_w, rf_address}, {1'b1, 5'd10}, "rstwr_pulse");
    #2 rst = 1'b1;
    #1;
    chk({req_ready, rsp_valid, rf_r_w}, 0, "rstwr_ctrl");
    chk({rf_address, rf_data_in, rf_reg1, rf_reg2}, 0, "rstwr_port");
    chk({rsp_rs_data, rsp_rt_data}, 0, "rstwr_rsp");
    tick();
    rst = 1'b0;
    exp_gap = -1;
    tick();
    chk(env_mem[10], model[10], "rstwr_no_write");
    chk(req_ready, 1, "rstwr_idle");
    present(42);
    run_txn(42, 0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
